// File: rtl/saturn_debug_uart.sv
// Debug character sink: buffers bytes from saturn_bus in a small FIFO and
// shifts them out as 8N1 UART frames, flagging when a halted CPU's output has fully left.
module saturn_debug_uart #(
  parameter int CLKS_PER_BIT    = 217,
  parameter int FIFO_DEPTH_LOG2 = 4
) (
  input  logic                     i_clk,
  input  logic                     i_reset,
  input  logic [7:0]               i_char,
  input  logic                     i_char_valid,
  input  logic                     i_halt,
  output logic                     o_tx,
  output logic                     o_full,
  output logic [FIFO_DEPTH_LOG2:0] o_level,
  output logic                     o_busy,
  output logic                     o_overflow,
  output logic                     o_drained
);

  localparam int DEPTH  = 1 << FIFO_DEPTH_LOG2;
  localparam int AW     = FIFO_DEPTH_LOG2;
  localparam int LW     = FIFO_DEPTH_LOG2 + 1;
  localparam int BAUD_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
  localparam logic [LW-1:0]     DEPTH_L   = LW'(DEPTH);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t          state;
  logic [7:0]      mem [DEPTH];
  logic [AW-1:0]   wr_ptr;
  logic [AW-1:0]   rd_ptr;
  logic [7:0]      shift;
  logic [2:0]      bit_idx;
  logic [BAUD_W-1:0] baud;

  logic            wr_en;
  logic            pop;
  logic            baud_done;
  logic            idle_next;
  logic [LW-1:0]   level_next;

  // Full test uses the pre-edge registered level, so a pop on the same edge cannot rescue a write.
  assign wr_en      = i_reset && i_char_valid && !o_full;
  assign pop        = (state == IDLE) && (o_level != '0);
  assign baud_done  = (baud == BAUD_LAST);
  assign level_next = o_level + LW'(wr_en) - LW'(pop);
  assign idle_next  = ((state == IDLE) && !pop) || ((state == STOP) && baud_done);
  assign o_busy     = (state != IDLE);

  always_ff @(posedge i_clk) begin
    if (wr_en) mem[wr_ptr] <= i_char;
  end

  always_ff @(posedge i_clk) begin
    if (!i_reset) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      o_level    <= '0;
      o_full     <= 1'b0;
      o_overflow <= 1'b0;
      o_drained  <= 1'b0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + AW'(1);
      if (pop)   rd_ptr <= rd_ptr + AW'(1);
      o_level <= level_next;
      o_full  <= (level_next == DEPTH_L);
      if (i_char_valid && o_full) o_overflow <= 1'b1;
      o_drained <= i_halt && (level_next == '0) && idle_next;
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_reset) begin
      state   <= IDLE;
      baud    <= '0;
      bit_idx <= '0;
      shift   <= '0;
      o_tx    <= 1'b1;
    end else begin
      case (state)
        IDLE: begin
          o_tx <= 1'b1;
          if (pop) begin
            shift <= mem[rd_ptr];
            baud  <= '0;
            state <= START;
            o_tx  <= 1'b0;
          end
        end
        START: begin
          if (baud_done) begin
            baud    <= '0;
            bit_idx <= '0;
            state   <= DATA;
            o_tx    <= shift[0];
          end else begin
            baud <= baud + BAUD_W'(1);
          end
        end
        DATA: begin
          if (baud_done) begin
            baud <= '0;
            if (bit_idx == 3'd7) begin
              state <= STOP;
              o_tx  <= 1'b1;
            end else begin
              bit_idx <= bit_idx + 3'd1;
              shift   <= {1'b0, shift[7:1]};
              o_tx    <= shift[1];
            end
          end else begin
            baud <= baud + BAUD_W'(1);
          end
        end
        STOP: begin
          o_tx <= 1'b1;
          if (baud_done) begin
            baud  <= '0;
            state <= IDLE;
          end else begin
            baud <= baud + BAUD_W'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
